// File: rtl/seq_auction.sv
// seq_auction
// Sequential sealed-bid auction engine. It collects 2^N unsigned bids, one per
// valid/ready handshake, and tracks the highest and second-highest bid as the
// bids arrive. When the last bid of a round is accepted it reports the winner
// index, the winning bid, the clearing price (first-price or second-price) and
// a reserve-not-met flag. Rounds can run back to back from DONE.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        begin a round (honoured in IDLE or DONE only)
//   mode         0 = first-price, 1 = second-price; sampled with start
//   reserve      minimum acceptable winning bid; sampled with start
//   bid_valid    bid present on bid
//   bid_ready    engine accepts a bid this cycle
//   bid          bid value; bidder index is arrival order 0..2^N-1
//   busy         round in progress
//   done         result valid
//   winner       index of the highest bidder
//   winning_bid  highest bid
//   price        clearing price
//   no_sale      winning_bid < reserve
module seq_auction #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] reserve,
  input  logic         bid_valid,
  output logic         bid_ready,
  input  logic [W-1:0] bid,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] winner,
  output logic [W-1:0] winning_bid,
  output logic [W-1:0] price,
  output logic         no_sale
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Index of the final bid of a round; the counter is one bit wider than the
  // index so it never wraps inside a round.
  localparam logic [N:0] LAST_IDX = {1'b0, {N{1'b1}}};

  state_t       state_reg;
  logic         busy_reg;
  logic         done_reg;
  logic         mode_reg;
  logic [W-1:0] reserve_reg;
  logic [N:0]   count_reg;
  logic [W-1:0] max_reg;
  logic [W-1:0] second_reg;
  logic [N-1:0] max_idx_reg;

  logic [N-1:0] winner_reg;
  logic [W-1:0] winning_bid_reg;
  logic [W-1:0] price_reg;
  logic         no_sale_reg;

  logic [W-1:0] max_next;
  logic [W-1:0] second_next;
  logic [N-1:0] max_idx_next;
  logic         accept;
  logic         last_bid;

  assign accept   = busy_reg && bid_valid;
  assign last_bid = (count_reg == LAST_IDX);

  // Running top-two update for the bid currently on the input. Strict '>'
  // keeps the earliest bidder on a tie for the top, while the tying bid still
  // lifts the runner-up so a second-price tie clears at the top bid.
  always_comb begin
    max_next     = max_reg;
    second_next  = second_reg;
    max_idx_next = max_idx_reg;
    if (bid > max_reg) begin
      second_next  = max_reg;
      max_next     = bid;
      max_idx_next = count_reg[N-1:0];
    end else if (bid > second_reg) begin
      second_next = bid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      mode_reg        <= 1'b0;
      reserve_reg     <= '0;
      count_reg       <= '0;
      max_reg         <= '0;
      second_reg      <= '0;
      max_idx_reg     <= '0;
      winner_reg      <= '0;
      winning_bid_reg <= '0;
      price_reg       <= '0;
      no_sale_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg   <= COLLECT;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
            mode_reg    <= mode;
            reserve_reg <= reserve;
            count_reg   <= '0;
            max_reg     <= '0;
            second_reg  <= '0;
            max_idx_reg <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            max_reg     <= max_next;
            second_reg  <= second_next;
            max_idx_reg <= max_idx_next;
            count_reg   <= count_reg + 1'b1;
            if (last_bid) begin
              // Results are loaded from the post-update values so the final
              // bid is included without an extra cycle.
              state_reg       <= DONE;
              busy_reg        <= 1'b0;
              done_reg        <= 1'b1;
              winner_reg      <= max_idx_next;
              winning_bid_reg <= max_next;
              price_reg       <= mode_reg ? second_next : max_next;
              no_sale_reg     <= (max_next < reserve_reg);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bid_ready   = busy_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign winner      = winner_reg;
  assign winning_bid = winning_bid_reg;
  assign price       = price_reg;
  assign no_sale     = no_sale_reg;

endmodule

// File: tb/tb_seq_auction.sv
// Directed testbench for seq_auction (N=2, W=8). Inputs are driven on the
// falling edge and outputs sampled on the falling edge, away from the active
// rising edge. Expected values are hand-computed constants.
module tb_seq_auction;

  localparam int N = 2;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [W-1:0] reserve;
  logic         bid_valid;
  logic         bid_ready;
  logic [W-1:0] bid;
  logic         busy;
  logic         done;
  logic [N-1:0] winner;
  logic [W-1:0] winning_bid;
  logic [W-1:0] price;
  logic         no_sale;

  int total = 0;
  int bad   = 0;

  seq_auction #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .reserve     (reserve),
    .bid_valid   (bid_valid),
    .bid_ready   (bid_ready),
    .bid         (bid),
    .busy        (busy),
    .done        (done),
    .winner      (winner),
    .winning_bid (winning_bid),
    .price       (price),
    .no_sale     (no_sale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_result(input string tag, input int exp_w, input int exp_wb,
                            input int exp_p, input int exp_ns);
    $display("round %s: winner=%0d winning_bid=%0d price=%0d no_sale=%0d",
             tag, winner, winning_bid, price, no_sale);
    chk({tag, "_winner"}, 32'(winner), 32'(exp_w));
    chk({tag, "_winning_bid"}, 32'(winning_bid), 32'(exp_wb));
    chk({tag, "_price"}, 32'(price), 32'(exp_p));
    chk({tag, "_no_sale"}, 32'(no_sale), 32'(exp_ns));
  endtask

  // Called on a falling edge; returns one falling edge later with the engine
  // expected to be collecting. mode/reserve are then scrambled to show they
  // are only sampled with start.
  task automatic start_round(input logic m, input logic [W-1:0] r);
    start   = 1'b1;
    mode    = m;
    reserve = r;
    @(negedge clk);
    start   = 1'b0;
    mode    = ~m;
    reserve = ~r;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(bid_ready), 32'd1);
    chk("start_done_low", 32'(done), 32'd0);
  endtask

  // Four contiguous bids; done must stay low until the cycle after the last.
  task automatic feed4(input logic [W-1:0] b0, input logic [W-1:0] b1,
                       input logic [W-1:0] b2, input logic [W-1:0] b3);
    logic [W-1:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int i = 0; i < 4; i++) begin
      chk("feed_done_early", 32'(done), 32'd0);
      bid_valid = 1'b1;
      bid       = bs[i];
      @(negedge clk);
    end
    bid_valid = 1'b0;
    chk("feed_done", 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic pat [7];
    int   accepts;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; reserve = '0;
    bid_valid = 1'b0; bid = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bid_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_result("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // First-price, duplicate top bid: done 5 cycles after start.
    start_round(1'b0, 8'd0);
    feed4(8'd10, 8'd40, 8'd25, 8'd40);
    chk_result("fp_10_40_25_40", 1, 40, 40, 0);

    start_round(1'b1, 8'd0);
    feed4(8'd5, 8'd9, 8'd3, 8'd7);
    chk_result("sp_5_9_3_7", 1, 9, 7, 0);

    start_round(1'b1, 8'd0);
    feed4(8'd10, 8'd40, 8'd25, 8'd40);
    chk_result("sp_10_40_25_40", 1, 40, 40, 0);

    start_round(1'b1, 8'd50);
    feed4(8'd12, 8'd30, 8'd48, 8'd7);
    chk_result("sp_res50", 2, 48, 30, 1);

    start_round(1'b1, 8'd48);
    feed4(8'd12, 8'd30, 8'd48, 8'd7);
    chk_result("sp_res48", 2, 48, 30, 0);

    // All-zero bids with bid_valid gaps; previous result held while collecting.
    start_round(1'b0, 8'd0);
    chk("stall_hold_bid", 32'(winning_bid), 32'd48);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    pat[4] = 1'b1; pat[5] = 1'b0; pat[6] = 1'b1;
    accepts = 0;
    for (int i = 0; i < 7; i++) begin
      chk("stall_ready", 32'(bid_ready), 32'd1);
      bid_valid = pat[i];
      bid       = '0;
      if (pat[i]) accepts++;
      @(negedge clk);
      chk("stall_done", 32'(done), (accepts == 4) ? 32'd1 : 32'd0);
    end
    // Valid while not ready is ignored.
    bid_valid = 1'b1;
    bid       = 8'd200;
    repeat (2) @(negedge clk);
    bid_valid = 1'b0;
    chk("done_ignore_ready", 32'(bid_ready), 32'd0);
    chk("done_ignore_done", 32'(done), 32'd1);
    chk_result("stall_zero", 0, 0, 0, 0);

    // Make outputs nonzero, then reset mid-round.
    start_round(1'b1, 8'd0);
    feed4(8'd1, 8'd7, 8'd3, 8'd2);
    chk_result("pre_reset", 1, 7, 3, 0);
    start_round(1'b1, 8'd0);
    bid_valid = 1'b1; bid = 8'd50;
    @(negedge clk);
    bid = 8'd60;
    @(negedge clk);
    bid_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(bid_ready), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk_result("midrst", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_done", 32'(done), 32'd0);
    start_round(1'b1, 8'd0);
    feed4(8'd1, 8'd2, 8'd3, 8'd4);
    chk_result("after_reset", 3, 4, 3, 0);

    // Restart from DONE with new mode/reserve; mid-round start is ignored.
    start_round(1'b0, 8'd100);
    chk_result("held", 3, 4, 3, 0);
    bid_valid = 1'b1; bid = 8'd5;
    @(negedge clk);
    bid = 8'd9; start = 1'b1; mode = 1'b1; reserve = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_busy", 32'(busy), 32'd1);
    chk("midstart_hold", 32'(winning_bid), 32'd4);
    bid = 8'd7;
    @(negedge clk);
    chk("midstart_done_early", 32'(done), 32'd0);
    bid = 8'd2;
    @(negedge clk);
    bid_valid = 1'b0;
    chk("midstart_done", 32'(done), 32'd1);
    chk_result("fp_res100", 1, 9, 9, 1);

    // start held through DONE: back-to-back rounds with a single DONE cycle.
    start = 1'b1; mode = 1'b1; reserve = 8'd0;
    @(negedge clk);
    chk("b2b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bid_valid = 1'b1;
      bid = (i == 0) ? 8'd3 : (i == 3) ? 8'd1 : 8'd8;
      @(negedge clk);
    end
    bid_valid = 1'b0;
    chk("b2b_done", 32'(done), 32'd1);
    chk_result("sp_tie_top", 1, 8, 8, 0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done_drop", 32'(done), 32'd0);
    chk("b2b_busy2", 32'(busy), 32'd1);
    feed4(8'd0, 8'd0, 8'd0, 8'd6);
    chk_result("b2b_second", 3, 6, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
